// File: rtl/spi_target_pkg.sv
// Shared defaults and state encoding for the SPI target block.
package spi_target_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_target_if.sv
// SPI pins plus the TX/RX byte handshake of the SPI target, bundled for port connection.
interface spi_target_if
  import spi_target_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  spi_sclk;
  logic                  spi_ss_n;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  busy;

  // The SPI target itself.
  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, tx_data, tx_valid,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  // The environment: SPI master pins plus the local byte producer/consumer.
  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, tx_data, tx_valid,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface

// File: rtl/spi_target_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
module spi_target_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sff <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sff[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sff[i] <= sff[i-1];
      end
    end
  end

  assign q = sff[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the SPI pins on the system clock, shifts
// frames in and out, and exposes a one-deep TX holding register.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic         io_systemClk,
  input  logic         io_asyncResetn,
  spi_target_if.slave  bus
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_d, ss_n_d;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-2:0] rx_sh;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  tx_underrun_q;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic                  tx_wr;
  logic                  frame_load;

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(io_systemClk), .rst_n(io_asyncResetn), .d(bus.spi_sclk), .q(sclk_s)
  );

  // Chip select idles high, so its chain resets to 1 to avoid a false select.
  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(io_systemClk), .rst_n(io_asyncResetn), .d(bus.spi_ss_n), .q(ss_n_s)
  );

  spi_target_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(io_systemClk), .rst_n(io_asyncResetn), .d(bus.spi_mosi), .q(mosi_s)
  );

  // One extra delay flop per edge-detected line.
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      sclk_d <= 1'b0;
      ss_n_d <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      ss_n_d <= ss_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_n_s & ss_n_d;
  assign ss_rise   = ss_n_s & ~ss_n_d;

  // A frame load happens on select and on the falling edge that closes a frame.
  assign frame_load = ((state == IDLE) && ss_fall) ||
                      ((state == ACTIVE) && !ss_rise && sclk_fall && (bit_cnt == '0));

  // Writes are only accepted while empty, so a same-cycle load always sees the old content.
  assign tx_wr = bus.tx_valid & ~hold_full;

  // One-deep TX holding register: filled by the producer, emptied by a frame load.
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (tx_wr) begin
      hold      <= bus.tx_data;
      hold_full <= 1'b1;
    end else if (frame_load) begin
      hold_full <= 1'b0;
    end
  end

  assign rx_next = {rx_sh, mosi_s};

  // Frame FSM with bit counter and TX/RX shift registers.
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;

      if (frame_load) begin
        tx_sh         <= hold_full ? hold : '0;
        tx_underrun_q <= ~hold_full;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= ACTIVE;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            // Partial frames are dropped silently.
            state   <= IDLE;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end else if (sclk_rise) begin
            rx_sh <= rx_next[DATA_WIDTH-2:0];
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              rx_data_q  <= rx_next;
              rx_valid_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall && (bit_cnt != '0)) begin
            tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_miso    = tx_sh[DATA_WIDTH-1];
  assign bus.spi_miso_oe = (state == ACTIVE);
  assign bus.busy        = (state == ACTIVE);
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed plus randomized bench for spi_target, driven as an SPI mode-0 master at 8x oversampling.
module tb_spi_target;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int HALF = 4;

  logic io_systemClk = 1'b0;
  logic io_asyncResetn = 1'b0;

  spi_target_if #(.DATA_WIDTH(DW)) bus ();

  spi_target #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .io_systemClk  (io_systemClk),
    .io_asyncResetn(io_asyncResetn),
    .bus           (bus)
  );

  always #5 io_systemClk = ~io_systemClk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed pulse counts and the last delivered frame.
  int          rx_seen  = 0;
  int          und_seen = 0;
  logic [DW-1:0] rx_last = '0;

  // Reference model: pending TX bytes, expected pulse counts, byte the shifter holds.
  logic [DW-1:0] pend_q[$];
  int            exp_rx  = 0;
  int            exp_und = 0;
  logic [DW-1:0] loaded  = '0;

  always @(negedge io_systemClk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_seen++;
      rx_last = bus.rx_data;
    end
    if (bus.tx_underrun === 1'b1) und_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge io_systemClk);
  endtask

  // Any frame load takes the pending byte, or zeros plus one underrun.
  task automatic model_load();
    if (pend_q.size() > 0) begin
      loaded = pend_q.pop_front();
    end else begin
      loaded = '0;
      exp_und++;
    end
  endtask

  task automatic push_tx(input logic [DW-1:0] v);
    check("tx_ready_before_write", 32'(bus.tx_ready), 32'(pend_q.size() == 0));
    bus.tx_data  = v;
    bus.tx_valid = 1'b1;
    tick(1);
    bus.tx_valid = 1'b0;
    pend_q.push_back(v);
    check("tx_ready_after_write", 32'(bus.tx_ready), 32'd0);
  endtask

  task automatic send_bit(input logic b, output logic m);
    bus.spi_mosi = b;
    tick(HALF);
    m = bus.spi_miso;
    bus.spi_sclk = 1'b1;
    tick(HALF);
    bus.spi_sclk = 1'b0;
  endtask

  task automatic select_target();
    bus.spi_ss_n = 1'b0;
    tick(HALF);
    model_load();
    check("busy_selected", 32'(bus.busy), 32'd1);
    check("oe_selected", 32'(bus.spi_miso_oe), 32'd1);
  endtask

  task automatic deselect_target();
    tick(2);
    bus.spi_ss_n = 1'b1;
    tick(SS + 2);
    check("busy_deselected", 32'(bus.busy), 32'd0);
    check("oe_deselected", 32'(bus.spi_miso_oe), 32'd0);
  endtask

  // Full frame; optionally writes wr_val into the holding register before bit wr_bit.
  task automatic frame(input logic [DW-1:0] mo, input int wr_bit, input logic [DW-1:0] wr_val,
                       output logic [DW-1:0] mi);
    logic m;
    mi = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (i == wr_bit) push_tx(wr_val);
      send_bit(mo[i], m);
      mi[i] = m;
    end
    tick(HALF);
    exp_rx++;
    model_load();
  endtask

  task automatic check_frame(input string tag, input logic [DW-1:0] mo,
                             input logic [DW-1:0] mi, input logic [DW-1:0] exp_mi);
    check({tag, "_miso"}, 32'(mi), 32'(exp_mi));
    check({tag, "_rx_data"}, 32'(rx_last), 32'(mo));
    check({tag, "_rx_count"}, 32'(rx_seen), 32'(exp_rx));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
    check({tag, "_oe"}, 32'(bus.spi_miso_oe), 32'd0);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_underrun"}, 32'(bus.tx_underrun), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] mi, cur, v, mo;
    logic m;
    int nf, wb;

    bus.spi_sclk = 1'b0;
    bus.spi_ss_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    tick(3);
    check_reset_outputs("reset");
    io_asyncResetn = 1'b1;
    tick(2);

    // Preloaded 0xA5 returned while 0x3C is received
    push_tx(8'hA5);
    select_target();
    cur = loaded;
    check("a5_tx_ready_after_select", 32'(bus.tx_ready), 32'd1);
    frame(8'h3C, -1, '0, mi);
    check_frame("a5", 8'h3C, mi, 8'hA5);
    check("a5_miso_literal", 32'(mi), 32'hA5);
    deselect_target();
    check("a5_underruns", 32'(und_seen), 32'(exp_und));

    // Empty holding register at select: zeros out, one underrun; refilled mid-frame
    v = DW'($urandom);
    select_target();
    cur = loaded;
    frame(8'hFF, 4, v, mi);
    check_frame("empty", 8'hFF, mi, 8'h00);
    deselect_target();
    check("empty_underruns", 32'(und_seen), 32'(exp_und));
    check("reload_not_restored", 32'(bus.tx_ready), 32'd1);

    // Two-frame burst with a write during frame one
    push_tx(8'h55);
    select_target();
    cur = loaded;
    frame(8'h12, 4, 8'hAA, mi);
    check_frame("burst1", 8'h12, mi, cur);
    cur = loaded;
    frame(8'h34, -1, '0, mi);
    check_frame("burst2", 8'h34, mi, cur);
    check("burst2_miso_literal", 32'(mi), 32'hAA);
    deselect_target();

    // Deselect after five bits: no frame delivered
    select_target();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), m);
    deselect_target();
    check("abort_rx_count", 32'(rx_seen), 32'(exp_rx));
    push_tx(8'hC3);
    select_target();
    cur = loaded;
    frame(8'h81, -1, '0, mi);
    check_frame("after_abort", 8'h81, mi, cur);
    deselect_target();

    // Reset asserted mid-frame
    push_tx(DW'($urandom));
    select_target();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), m);
    tick(1);
    io_asyncResetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    bus.spi_ss_n = 1'b1;
    bus.spi_sclk = 1'b0;
    pend_q.delete();
    tick(3);
    io_asyncResetn = 1'b1;
    tick(2);
    select_target();
    cur = loaded;
    frame(8'h7E, -1, '0, mi);
    check_frame("post_reset", 8'h7E, mi, cur);
    deselect_target();
    check("post_reset_underruns", 32'(und_seen), 32'(exp_und));

    // SCLK toggling while deselected is ignored
    v = DW'($urandom);
    push_tx(v);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'($urandom), m);
      check("idle_oe", 32'(bus.spi_miso_oe), 32'd0);
    end
    check("idle_rx_count", 32'(rx_seen), 32'(exp_rx));
    check("idle_tx_held", 32'(bus.tx_ready), 32'd0);
    check("idle_underruns", 32'(und_seen), 32'(exp_und));
    select_target();
    cur = loaded;
    frame(DW'($urandom), -1, '0, mi);
    check("idle_then_miso", 32'(mi), 32'(v));
    deselect_target();

    // Randomized bursts against the model
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1) == 1) push_tx(DW'($urandom));
      select_target();
      cur = loaded;
      nf = int'($urandom_range(3, 1));
      for (int f = 0; f < nf; f++) begin
        wb = ($urandom_range(1) == 1 && pend_q.size() == 0) ? int'($urandom_range(6, 1)) : -1;
        mo = DW'($urandom);
        frame(mo, wb, DW'($urandom), mi);
        check_frame("rand", mo, mi, cur);
        cur = loaded;
      end
      deselect_target();
      check("rand_underruns", 32'(und_seen), 32'(exp_und));
      check("rand_tx_ready", 32'(bus.tx_ready), 32'(pend_q.size() == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SPI frame width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth for spi_sclk, spi_ss_n and spi_mosi.
REQ-003 io_systemClk  in  1  sole clock; the only clock in the block.
REQ-004 io_asyncResetn  in  1  reset, asynchronous and active-low.
REQ-005 spi_sclk  in  1  SPI clock from the SoC SPI master, mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_ss_n  in  1  chip select, active-low.
REQ-007 spi_mosi  in  1  master-out data, MSB first.
REQ-008 spi_miso  out  1  target-out data, MSB first.
REQ-009 spi_miso_oe  out  1  MISO output enable, high only while selected.
REQ-010 tx_data  in  DATA_WIDTH  next byte to return to the master.
REQ-011 tx_valid  in  1  tx_data valid.
REQ-012 tx_ready  out  1  one-deep TX holding register empty.
REQ-013 rx_data  out  DATA_WIDTH  last complete received frame.
REQ-014 rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-015 tx_underrun  out  1  one-cycle pulse when a frame load finds the holding register empty.
REQ-016 busy  out  1  high while in state ACTIVE.

Function
REQ-017 The block SHALL sample spi_sclk, spi_ss_n and spi_mosi through SYNC_STAGES flops, then detect edges from the last stage against one extra delay flop.
REQ-018 Supported ratio: io_systemClk frequency >= 8 x spi_sclk frequency; behaviour above that SCLK rate is undefined.
REQ-019 The FSM SHALL have exactly two states:
  - IDLE -> ACTIVE on a detected spi_ss_n falling edge.
  - ACTIVE -> IDLE on a detected spi_ss_n rising edge.
REQ-020 On entry to ACTIVE:
  - bit counter cleared to 0;
  - TX shift register loaded from the holding register;
  - holding register marked empty.
REQ-021 If the holding register is empty at any frame load, the TX shift register SHALL load all-zeros and tx_underrun SHALL pulse once.
REQ-022 spi_miso SHALL equal TX shift register MSB; spi_miso_oe SHALL equal (state==ACTIVE).
REQ-023 On each detected SCLK rising edge in ACTIVE:
  - synchronized MOSI shifts into the RX shift register LSB;
  - bit counter increments modulo DATA_WIDTH.
REQ-024 When the counter wraps to 0, the block SHALL copy the assembled frame to rx_data and pulse rx_valid on the same cycle.
REQ-025 rx_data SHALL hold its value until the next completed frame; there is no backpressure, and the consumer must take rx_data within one frame time.
REQ-026 On each detected SCLK falling edge in ACTIVE:
  - bit counter == 0: reload the TX shift register per REQ-020/021;
  - otherwise: shift the TX shift register left by one.
REQ-027 tx_valid && tx_ready SHALL write the holding register; tx_ready drops the next cycle.
REQ-028 tx_ready SHALL rise the cycle after a load consumes the holding register.
REQ-029 If a load and a write fall on the same cycle, the load takes the old content and the write is refused, because tx_ready was low.
REQ-030 On spi_ss_n deassertion mid-frame, the block SHALL:
  - discard the partial RX frame, with no rx_valid;
  - clear the bit counter;
  - drop spi_miso_oe on the next cycle.
REQ-031 A frame loaded at the final falling edge SHALL be discarded if spi_ss_n then rises; it is not restored to the holding register.
REQ-032 SCLK edges detected in IDLE SHALL be ignored.

Reset
REQ-033 While io_asyncResetn is low, all outputs SHALL read:
  - spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_underrun=0, busy=0;
  - tx_ready=1;
  - state IDLE, counters and shift registers 0, synchronizer flops 1 for spi_ss_n and 0 for the others.
REQ-034 Reset deassertion is synchronized externally; the block SHALL need no cycle of settling after release.

Structure
REQ-035 Package spi_target_pkg SHALL hold DATA_WIDTH and SYNC_STAGES defaults plus the state enumeration (IDLE, ACTIVE).
REQ-036 One sub-module spi_target_sync SHALL implement the per-bit SYNC_STAGES synchronizer with a reset value parameter; it is instantiated three times.

Verification
REQ-037 tx 0xA5 preloaded, master sends 0x3C at ratio 8 -> master reads 0xA5; rx_data=0x3C, one rx_valid pulse; tx_ready high after SS fall.
REQ-038 Holding register empty at SS fall, master sends 0xFF -> MISO all zeros; exactly one tx_underrun; rx_data=0xFF.
REQ-039 Two-frame burst 0x12,0x34 with tx 0x55, then 0xAA written mid-frame-1 -> master reads 0x55,0xAA; two rx_valid pulses.
REQ-040 SS rises after 5 SCLK edges -> no rx_valid; busy and spi_miso_oe low within SYNC_STAGES+2 cycles; next frame 0x81 receives correctly.
REQ-041 io_asyncResetn asserted mid-frame -> all outputs at REQ-033 values immediately; after release and a new SS cycle, 0x7E is received correctly.
REQ-042 SCLK toggling while spi_ss_n high -> no rx_valid, no tx consumption, spi_miso_oe stays 0.
